// File: rtl/note_player.sv
// Note sequencer for the music-box tone generator: one playing note plus one queued note.
// Optional NOTE_PLAYER_TEMPO_EN adds tempo_sel_i to scale the beat length per note.
module note_player #(
  parameter int BEAT_CYCLES = 6250000,
  parameter int GAP_CYCLES  = 250000,
  parameter int DIV_W       = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             note_valid_i,
  input  logic [3:0]       note_pitch_i,
  input  logic [2:0]       note_len_i,
`ifdef NOTE_PLAYER_TEMPO_EN
  input  logic [1:0]       tempo_sel_i,
`endif
  output logic             note_ready_o,
  output logic [DIV_W-1:0] half_period_o,
  output logic             tone_en_o,
  output logic             busy_o,
  output logic             note_done_o
);

`ifdef NOTE_PLAYER_TEMPO_EN
  localparam int BEAT_MAX  = BEAT_CYCLES * 2;
`else
  localparam int BEAT_MAX  = BEAT_CYCLES;
`endif
  localparam int HALF_BEAT = (BEAT_CYCLES / 2 > 0) ? BEAT_CYCLES / 2 : 1;
  localparam int CYC_W     = $clog2(BEAT_MAX + 1);
  localparam int GAP_W     = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   hp_q, hp_d;
  logic               tone_q, tone_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d, term_q, term_d, ld_term;
  logic [2:0]         beat_q, beat_d, len_q, len_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               bufv_q, bufv_d;
  logic [3:0]         bufp_q, bufp_d, ld_pitch;
  logic [2:0]         bufl_q, bufl_d, ld_len;
  logic               xfer, gap_end, load;

  function automatic logic [DIV_W-1:0] pitch_div(input logic [3:0] p);
    case (p)
      4'd1:    pitch_div = DIV_W'(23889);
      4'd2:    pitch_div = DIV_W'(22548);
      4'd3:    pitch_div = DIV_W'(21282);
      4'd4:    pitch_div = DIV_W'(20088);
      4'd5:    pitch_div = DIV_W'(18960);
      4'd6:    pitch_div = DIV_W'(17896);
      4'd7:    pitch_div = DIV_W'(16892);
      4'd8:    pitch_div = DIV_W'(15944);
      4'd9:    pitch_div = DIV_W'(15049);
      4'd10:   pitch_div = DIV_W'(14204);
      4'd11:   pitch_div = DIV_W'(13407);
      4'd12:   pitch_div = DIV_W'(12654);
      default: pitch_div = '0;
    endcase
  endfunction

  // Per-note terminal value of the cycle counter (beat length minus one).
`ifdef NOTE_PLAYER_TEMPO_EN
  always_comb begin
    case (tempo_sel_i)
      2'b01:   ld_term = CYC_W'(HALF_BEAT - 1);
      2'b10:   ld_term = CYC_W'(BEAT_CYCLES * 2 - 1);
      default: ld_term = CYC_W'(BEAT_CYCLES - 1);
    endcase
  end
`else
  assign ld_term = CYC_W'(BEAT_CYCLES - 1);
`endif

  assign xfer    = note_valid_i && !bufv_q;
  assign gap_end = (gap_q == GAP_W'(GAP_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    hp_d     = hp_q;
    tone_d   = tone_q;
    cyc_d    = cyc_q;
    beat_d   = beat_q;
    gap_d    = gap_q;
    len_d    = len_q;
    term_d   = term_q;
    bufv_d   = bufv_q;
    bufp_d   = bufp_q;
    bufl_d   = bufl_q;
    load     = 1'b0;
    ld_pitch = note_pitch_i;
    ld_len   = note_len_i;
    case (state_q)
      IDLE: load = xfer;
      PLAY: begin
        if (xfer) begin
          bufv_d = 1'b1;
          bufp_d = note_pitch_i;
          bufl_d = note_len_i;
        end
        if (cyc_q == term_q) begin
          cyc_d = '0;
          if (beat_q == len_q) begin
            state_d = GAP;
            tone_d  = 1'b0;
            beat_d  = '0;
            gap_d   = '0;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      GAP: begin
        if (gap_end) begin
          // A queued note wins; otherwise a note offered now bypasses the buffer.
          if (bufv_q) begin
            load     = 1'b1;
            ld_pitch = bufp_q;
            ld_len   = bufl_q;
            bufv_d   = 1'b0;
          end else if (xfer) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            hp_d    = '0;
            gap_d   = '0;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
          if (xfer) begin
            bufv_d = 1'b1;
            bufp_d = note_pitch_i;
            bufl_d = note_len_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = PLAY;
      hp_d    = pitch_div(ld_pitch);
      tone_d  = (ld_pitch != 4'd0) && (ld_pitch <= 4'd12);
      len_d   = ld_len;
      term_d  = ld_term;
      cyc_d   = '0;
      beat_d  = '0;
      gap_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hp_q    <= '0;
      tone_q  <= 1'b0;
      cyc_q   <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      len_q   <= '0;
      term_q  <= '0;
      bufv_q  <= 1'b0;
      bufp_q  <= '0;
      bufl_q  <= '0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      tone_q  <= tone_d;
      cyc_q   <= cyc_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      len_q   <= len_d;
      term_q  <= term_d;
      bufv_q  <= bufv_d;
      bufp_q  <= bufp_d;
      bufl_q  <= bufl_d;
    end
  end

  assign note_ready_o  = !bufv_q;
  assign half_period_o = hp_q;
  assign tone_en_o     = tone_q;
  assign busy_o        = (state_q != IDLE);
  assign note_done_o   = (state_q == GAP) && gap_end;

endmodule
